// File: rtl/edge_bbox_stat.sv
// Per-frame edge statistics: counts edge pixels and tracks their bounding box,
// latching the results and pulsing frame_done at every armed frame end.
module edge_bbox_stat #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_img_vsync,
  input  logic        per_img_href,
  input  logic        per_img_clken,
  input  logic        per_img_bit,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic [21:0] edge_cnt,
  output logic        box_valid,
  output logic        frame_done
);

  localparam logic [21:0] CNT_MAX = 22'h3FFFFF;

  logic        vsync_d_reg;
  logic        href_d_reg;
  logic        seen_low_reg;
  logic        armed_reg;
  logic [10:0] x_reg;
  logic [10:0] y_reg;
  logic [21:0] acc_cnt_reg;
  logic [10:0] acc_xmin_reg;
  logic [10:0] acc_xmax_reg;
  logic [10:0] acc_ymin_reg;
  logic [10:0] acc_ymax_reg;
  logic        found_reg;

  logic pix_v;
  logic frame_start;
  logic frame_end;
  logic line_end;
  logic hit;
  logic first_hit;

  assign pix_v       = per_img_vsync & per_img_href & per_img_clken;
  assign frame_start = per_img_vsync & ~vsync_d_reg;
  assign frame_end   = ~per_img_vsync & vsync_d_reg;
  assign line_end    = ~per_img_href & href_d_reg;
  assign hit         = pix_v & per_img_bit & (x_reg < IMG_HDISP) & (y_reg < IMG_VDISP);
  // A pixel coinciding with frame start sees freshly cleared accumulators.
  assign first_hit   = frame_start | ~found_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_reg  <= 1'b0;
      href_d_reg   <= 1'b0;
      seen_low_reg <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      vsync_d_reg <= per_img_vsync;
      href_d_reg  <= per_img_href;
      if (!per_img_vsync)
        seen_low_reg <= 1'b1;
      // Only a start observed after a genuine low phase arms reporting, so a
      // frame already running at reset release is discarded.
      if (frame_start && seen_low_reg)
        armed_reg <= 1'b1;
      else if (frame_end)
        armed_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= 11'd0;
      y_reg <= 11'd0;
    end else begin
      if (!per_img_href)
        x_reg <= 11'd0;
      else if (pix_v && (x_reg < IMG_HDISP))
        x_reg <= x_reg + 11'd1;

      if (!per_img_vsync || frame_start)
        y_reg <= 11'd0;
      else if (line_end && (y_reg < IMG_VDISP))
        y_reg <= y_reg + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_reg  <= 22'd0;
      acc_xmin_reg <= 11'd0;
      acc_xmax_reg <= 11'd0;
      acc_ymin_reg <= 11'd0;
      acc_ymax_reg <= 11'd0;
      found_reg    <= 1'b0;
    end else begin
      if (frame_start) begin
        acc_cnt_reg  <= 22'd0;
        acc_xmin_reg <= 11'd0;
        acc_xmax_reg <= 11'd0;
        acc_ymin_reg <= 11'd0;
        acc_ymax_reg <= 11'd0;
        found_reg    <= 1'b0;
      end
      if (hit) begin
        if (first_hit) begin
          acc_cnt_reg  <= 22'd1;
          acc_xmin_reg <= x_reg;
          acc_xmax_reg <= x_reg;
          acc_ymin_reg <= y_reg;
          acc_ymax_reg <= y_reg;
          found_reg    <= 1'b1;
        end else begin
          if (acc_cnt_reg != CNT_MAX)
            acc_cnt_reg <= acc_cnt_reg + 22'd1;
          if (x_reg < acc_xmin_reg)
            acc_xmin_reg <= x_reg;
          if (x_reg > acc_xmax_reg)
            acc_xmax_reg <= x_reg;
          if (y_reg < acc_ymin_reg)
            acc_ymin_reg <= y_reg;
          if (y_reg > acc_ymax_reg)
            acc_ymax_reg <= y_reg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_xmin   <= 11'd0;
      box_xmax   <= 11'd0;
      box_ymin   <= 11'd0;
      box_ymax   <= 11'd0;
      edge_cnt   <= 22'd0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_end && armed_reg) begin
        box_xmin   <= found_reg ? acc_xmin_reg : 11'd0;
        box_xmax   <= found_reg ? acc_xmax_reg : 11'd0;
        box_ymin   <= found_reg ? acc_ymin_reg : 11'd0;
        box_ymax   <= found_reg ? acc_ymax_reg : 11'd0;
        edge_cnt   <= found_reg ? acc_cnt_reg : 22'd0;
        box_valid  <= found_reg;
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edge_bbox_stat.sv
// Directed bench for edge_bbox_stat: a full-size instance plus an 8x4 instance
// driven from the same edge stream.
module tb_edge_bbox_stat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        clken = 1'b0;
  logic        ebit = 1'b0;

  logic [10:0] xmin, xmax, ymin, ymax;
  logic [21:0] cnt;
  logic        valid, done;
  logic [10:0] s_xmin, s_xmax, s_ymin, s_ymax;
  logic [21:0] s_cnt;
  logic        s_valid, s_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;

  int spec_y[$];
  int spec_len[$];
  int spec_a[$];
  int spec_b[$];

  edge_bbox_stat dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vsync), .per_img_href(href), .per_img_clken(clken), .per_img_bit(ebit),
    .box_xmin(xmin), .box_xmax(xmax), .box_ymin(ymin), .box_ymax(ymax),
    .edge_cnt(cnt), .box_valid(valid), .frame_done(done)
  );

  edge_bbox_stat #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vsync), .per_img_href(href), .per_img_clken(clken), .per_img_bit(ebit),
    .box_xmin(s_xmin), .box_xmax(s_xmax), .box_ymin(s_ymin), .box_ymax(s_ymax),
    .edge_cnt(s_cnt), .box_valid(s_valid), .frame_done(s_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (s_done) s_done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vsync = 1'b0; href = 1'b0; clken = 1'b0; ebit = 1'b0;
    repeat (n) step();
  endtask

  // Lines default to one blank pixel; spec_* entries give a line its length
  // and up to two edge columns. gap inserts a clken-low, bit-high cycle before
  // every strobe and sets every strobed bit.
  task automatic run_frame(input int nlines, input bit gap, input int glen);
    int len, a, b;
    vsync = 1'b1; href = 1'b0; clken = 1'b0; ebit = 1'b0;
    step();
    for (int l = 0; l < nlines; l++) begin
      len = 1; a = -1; b = -1;
      for (int k = 0; k < spec_y.size(); k++)
        if (spec_y[k] == l) begin
          len = spec_len[k]; a = spec_a[k]; b = spec_b[k];
        end
      if (gap) len = glen;
      for (int i = 0; i < len; i++) begin
        if (gap) begin
          href = 1'b1; clken = 1'b0; ebit = 1'b1;
          step();
        end
        href = 1'b1; clken = 1'b1;
        ebit = gap ? 1'b1 : ((i == a) || (i == b));
        step();
      end
      href = 1'b0; clken = 1'b0; ebit = 1'b0;
      step();
      step();
    end
    idle(4);
  endtask

  task automatic spec_clear();
    spec_y.delete(); spec_len.delete(); spec_a.delete(); spec_b.delete();
  endtask

  task automatic spec_add(input int y, input int len, input int a, input int b);
    spec_y.push_back(y); spec_len.push_back(len); spec_a.push_back(a); spec_b.push_back(b);
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (xmin !== 11'd0)  begin errors++; $display("FAIL reset_xmin got %0d want 0", xmin); end
    checks++; if (xmax !== 11'd0)  begin errors++; $display("FAIL reset_xmax got %0d want 0", xmax); end
    checks++; if (ymin !== 11'd0)  begin errors++; $display("FAIL reset_ymin got %0d want 0", ymin); end
    checks++; if (ymax !== 11'd0)  begin errors++; $display("FAIL reset_ymax got %0d want 0", ymax); end
    checks++; if (cnt !== 22'd0)   begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (s_cnt !== 22'd0) begin errors++; $display("FAIL reset_s_cnt got %0d want 0", s_cnt); end
    checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL reset_s_done got %0b want 0", s_done); end
    rst_n = 1'b1;
    idle(3);
    $display("reset: outputs zero after reset");
  endtask

  // One edge at (100,50); a 645-pixel line with edges at x=640 and x=644 must be ignored.
  task automatic test_single();
    int d0 = done_cnt;
    spec_clear();
    spec_add(50, 101, 100, 100);
    spec_add(60, 645, 640, 644);
    run_frame(61, 1'b0, 0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (xmin !== 11'd100) begin errors++; $display("FAIL single_xmin got %0d want 100", xmin); end
    checks++; if (xmax !== 11'd100) begin errors++; $display("FAIL single_xmax got %0d want 100", xmax); end
    checks++; if (ymin !== 11'd50)  begin errors++; $display("FAIL single_ymin got %0d want 50", ymin); end
    checks++; if (ymax !== 11'd50)  begin errors++; $display("FAIL single_ymax got %0d want 50", ymax); end
    checks++; if (cnt !== 22'd1)    begin errors++; $display("FAIL single_cnt got %0d want 1", cnt); end
    checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL single_valid got %0b want 1", valid); end
    $display("single: box %0d..%0d x %0d..%0d cnt %0d", xmin, xmax, ymin, ymax, cnt);
  endtask

  // Edges at (10,20), (600,20), (300,470); an edge at line 480 must be ignored.
  task automatic test_bbox();
    int d0 = done_cnt;
    spec_clear();
    spec_add(20, 601, 10, 600);
    spec_add(470, 301, 300, 300);
    spec_add(480, 6, 5, 5);
    run_frame(482, 1'b0, 0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bbox_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (xmin !== 11'd10)  begin errors++; $display("FAIL bbox_xmin got %0d want 10", xmin); end
    checks++; if (xmax !== 11'd600) begin errors++; $display("FAIL bbox_xmax got %0d want 600", xmax); end
    checks++; if (ymin !== 11'd20)  begin errors++; $display("FAIL bbox_ymin got %0d want 20", ymin); end
    checks++; if (ymax !== 11'd470) begin errors++; $display("FAIL bbox_ymax got %0d want 470", ymax); end
    checks++; if (cnt !== 22'd3)    begin errors++; $display("FAIL bbox_cnt got %0d want 3", cnt); end
    checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL bbox_valid got %0b want 1", valid); end
    $display("bbox: box %0d..%0d x %0d..%0d cnt %0d", xmin, xmax, ymin, ymax, cnt);
  endtask

  task automatic test_zero();
    int d0 = done_cnt;
    spec_clear();
    run_frame(5, 1'b0, 0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL zero_valid got %0b want 0", valid); end
    checks++; if (xmin !== 11'd0)   begin errors++; $display("FAIL zero_xmin got %0d want 0", xmin); end
    checks++; if (xmax !== 11'd0)   begin errors++; $display("FAIL zero_xmax got %0d want 0", xmax); end
    checks++; if (ymin !== 11'd0)   begin errors++; $display("FAIL zero_ymin got %0d want 0", ymin); end
    checks++; if (ymax !== 11'd0)   begin errors++; $display("FAIL zero_ymax got %0d want 0", ymax); end
    checks++; if (cnt !== 22'd0)    begin errors++; $display("FAIL zero_cnt got %0d want 0", cnt); end
    $display("zero: valid %0b cnt %0d", valid, cnt);
  endtask

  // Edge at (3,0) in the last vsync-high cycle; href falls together with vsync.
  task automatic test_last_cycle();
    vsync = 1'b1; href = 1'b0; clken = 1'b0; ebit = 1'b0;
    step();
    href = 1'b1; clken = 1'b1;
    repeat (3) step();
    ebit = 1'b1;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL last_done_early got %0b want 0", done); end
    vsync = 1'b0; href = 1'b0; clken = 1'b0; ebit = 1'b0;
    step();
    checks++; if (done !== 1'b1)   begin errors++; $display("FAIL last_done_rise got %0b want 1", done); end
    checks++; if (cnt !== 22'd1)   begin errors++; $display("FAIL last_cnt got %0d want 1", cnt); end
    checks++; if (xmin !== 11'd3)  begin errors++; $display("FAIL last_xmin got %0d want 3", xmin); end
    checks++; if (ymax !== 11'd0)  begin errors++; $display("FAIL last_ymax got %0d want 0", ymax); end
    checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL last_valid got %0b want 1", valid); end
    step();
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL last_done_fall got %0b want 0", done); end
    idle(3);
    $display("last_cycle: edge in final vsync cycle counted, cnt %0d", cnt);
  endtask

  // Five lines of 10 strobes, clken low every other cycle, bit high throughout.
  task automatic test_small();
    int d0 = s_done_cnt;
    spec_clear();
    run_frame(5, 1'b1, 10);
    checks++; if (s_done_cnt - d0 !== 1) begin errors++; $display("FAIL small_done_pulses got %0d want 1", s_done_cnt - d0); end
    checks++; if (s_cnt !== 22'd32)  begin errors++; $display("FAIL small_cnt got %0d want 32", s_cnt); end
    checks++; if (s_xmin !== 11'd0)  begin errors++; $display("FAIL small_xmin got %0d want 0", s_xmin); end
    checks++; if (s_xmax !== 11'd7)  begin errors++; $display("FAIL small_xmax got %0d want 7", s_xmax); end
    checks++; if (s_ymin !== 11'd0)  begin errors++; $display("FAIL small_ymin got %0d want 0", s_ymin); end
    checks++; if (s_ymax !== 11'd3)  begin errors++; $display("FAIL small_ymax got %0d want 3", s_ymax); end
    checks++; if (s_valid !== 1'b1)  begin errors++; $display("FAIL small_valid got %0b want 1", s_valid); end
    checks++; if (cnt !== 22'd50)    begin errors++; $display("FAIL full_gap_cnt got %0d want 50", cnt); end
    checks++; if (xmax !== 11'd9)    begin errors++; $display("FAIL full_gap_xmax got %0d want 9", xmax); end
    checks++; if (ymax !== 11'd4)    begin errors++; $display("FAIL full_gap_ymax got %0d want 4", ymax); end
    $display("small: cnt %0d box %0d..%0d x %0d..%0d", s_cnt, s_xmin, s_xmax, s_ymin, s_ymax);
  endtask

  task automatic test_mid_reset();
    int d0;
    vsync = 1'b1; href = 1'b0; clken = 1'b0; ebit = 1'b0;
    step();
    href = 1'b1; clken = 1'b1; ebit = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if (cnt !== 22'd0)  begin errors++; $display("FAIL midrst_cnt_clear got %0d want 0", cnt); end
    checks++; if (xmax !== 11'd0) begin errors++; $display("FAIL midrst_xmax_clear got %0d want 0", xmax); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_clear got %0b want 0", valid); end
    repeat (3) step();
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int l = 0; l < 2; l++) begin
      href = 1'b1; clken = 1'b1; ebit = 1'b1;
      repeat (5) step();
      href = 1'b0; clken = 1'b0; ebit = 1'b0;
      repeat (2) step();
    end
    idle(4);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_partial_pulses got %0d want 0", done_cnt - d0); end
    checks++; if (cnt !== 22'd0) begin errors++; $display("FAIL midrst_partial_cnt got %0d want 0", cnt); end
    d0 = done_cnt;
    spec_clear();
    spec_add(2, 8, 7, 7);
    run_frame(4, 1'b0, 0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_next_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (cnt !== 22'd1)   begin errors++; $display("FAIL midrst_next_cnt got %0d want 1", cnt); end
    checks++; if (xmin !== 11'd7)  begin errors++; $display("FAIL midrst_next_xmin got %0d want 7", xmin); end
    checks++; if (ymin !== 11'd2)  begin errors++; $display("FAIL midrst_next_ymin got %0d want 2", ymin); end
    checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL midrst_next_valid got %0b want 1", valid); end
    $display("mid_reset: partial frame discarded, next frame cnt %0d at (%0d,%0d)", cnt, xmin, ymin);
  endtask

  initial begin
    test_reset();
    test_single();
    test_bbox();
    test_zero();
    test_last_cycle();
    test_small();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
